// File: rtl/decode_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode-stage ROB allocator: field widths of the
// ROB tag, architectural register index and fetch id, the allocator FSM
// state type and the default allocation-blackout length after a flush.
// ---------------------------------------------------------------------------
package decode_pkg;

    localparam int ROB_TAG_W            = 4;
    localparam int ARCH_REG_W           = 5;
    localparam int FID_W                = 8;
    // Occupancy needs one more bit than the tag so that "full" (16) fits.
    localparam int COUNT_W              = ROB_TAG_W + 1;
    // Blackout counter width; holds FLUSH_CYCLES in 1..15.
    localparam int BLK_W                = 4;
    localparam int DEFAULT_FLUSH_CYCLES = 2;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

endpackage

// File: rtl/decode_rob_ptr.sv
// ---------------------------------------------------------------------------
// decode_rob_ptr
// Circular head/tail tracker for the ROB. Pointers carry one extra wrap bit
// so occupancy is simply tail - head, which distinguishes full from empty.
//
// Ports:
//   clk       in   clock
//   rst_ni    in   asynchronous active-low reset
//   alloc_i   in   advance tail (caller guarantees not full)
//   commit_i  in   advance head (caller guarantees not empty)
//   clear_i   in   reset both pointers to 0 (wins over alloc/commit)
//   tail_o    out  ROB tag of the next allocation
//   count_o   out  occupied entries, 0..DEPTH
//   full_o    out  count_o == DEPTH
//   empty_o   out  count_o == 0
// ---------------------------------------------------------------------------
module decode_rob_ptr
    import decode_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_ni,
    input  logic                 alloc_i,
    input  logic                 commit_i,
    input  logic                 clear_i,
    output logic [ROB_TAG_W-1:0] tail_o,
    output logic [COUNT_W-1:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [PTR_W-1:0] occ;

    // DEPTH is a power of two, so natural PTR_W-bit overflow is the wrap.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        if (clear_i) begin
            head_d = '0;
            tail_d = '0;
        end else begin
            if (alloc_i)  tail_d = tail_q + PTR_W'(1);
            if (commit_i) head_d = head_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ     = tail_q - head_q;
    assign count_o = COUNT_W'(occ);
    assign full_o  = (occ == PTR_W'(DEPTH));
    assign empty_o = (occ == '0);
    assign tail_o  = ROB_TAG_W'(tail_q[IDX_W-1:0]);

endmodule

// File: rtl/decode_rob_alloc.sv
// ---------------------------------------------------------------------------
// decode_rob_alloc
// In-order ROB tag allocator between decode and the RAT. Hands out tags from
// a circular pointer pair, forwards allocations and commits to the RAT write
// ports, and sequences recovery on branch correction / snoop hit: one-cycle
// flush pulse to the RAT, pointer clear, then FLUSH_CYCLES of blackout.
//
// Optional build macro DECODE_ROB_ALLOC_STALL_CNT_EN adds stall_cnt, a
// saturating count of cycles where decode was held off (s_valid & ~s_ready).
//
// Ports:
//   clk, resetn                      clock, async active-low reset
//   s_valid/s_ready/s_dst/s_dst_we/s_fid, s_rob   decode allocation handshake
//   c_valid/c_dst/c_dst_we/c_fid     in-order commit of the oldest entry
//   bco_in, snoop_in                 recovery requests
//   rat_wec/addrc/dinc_fid/dinc_rob  RAT allocate port
//   rat_wee/addre/dine_fid           RAT commit port
//   rat_bco, rat_snoop               registered RAT flush pulses
//   count                            occupied ROB entries
//   err_underflow                    sticky: commit seen while empty
//   stall_cnt (optional)             saturating stall-cycle counter
// ---------------------------------------------------------------------------
module decode_rob_alloc
    import decode_pkg::*;
#(
    parameter int ROB_DEPTH    = 16,
    parameter int FLUSH_CYCLES = DEFAULT_FLUSH_CYCLES
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [ARCH_REG_W-1:0] s_dst,
    input  logic                  s_dst_we,
    input  logic [FID_W-1:0]      s_fid,
    output logic [ROB_TAG_W-1:0]  s_rob,
    input  logic                  c_valid,
    input  logic [ARCH_REG_W-1:0] c_dst,
    input  logic                  c_dst_we,
    input  logic [FID_W-1:0]      c_fid,
    input  logic                  bco_in,
    input  logic                  snoop_in,
    output logic                  rat_wec,
    output logic [ARCH_REG_W-1:0] rat_addrc,
    output logic [FID_W-1:0]      rat_dinc_fid,
    output logic [ROB_TAG_W-1:0]  rat_dinc_rob,
    output logic                  rat_wee,
    output logic [ARCH_REG_W-1:0] rat_addre,
    output logic [FID_W-1:0]      rat_dine_fid,
    output logic                  rat_bco,
    output logic                  rat_snoop,
    output logic [COUNT_W-1:0]    count,
    output logic                  err_underflow
`ifdef DECODE_ROB_ALLOC_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam logic [BLK_W-1:0] FLUSH_LOAD = BLK_W'(FLUSH_CYCLES);

    state_e            state_q, state_d;
    logic [BLK_W-1:0]  blk_cnt_q, blk_cnt_d;
    logic              rat_bco_q, rat_snoop_q;
    logic              err_q, err_d;

    logic              flush_req;
    logic              run_ready;
    logic              commit_go;
    logic              alloc_en;
    logic              commit_en;
    logic              full, empty;
    logic [ROB_TAG_W-1:0] tail;

    assign flush_req = bco_in | snoop_in;

    // ------------------------------------------------------------------
    // FSM next state / decisions
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        blk_cnt_d = blk_cnt_q;
        err_d     = err_q;
        run_ready = 1'b0;
        commit_go = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                // No same-cycle refill at full: readiness looks only at the
                // current occupancy, not at a concurrent commit.
                run_ready = ~full & ~flush_req;
                commit_go = c_valid & ~empty & ~flush_req;
                if (c_valid & empty & ~flush_req) err_d = 1'b1;
                if (flush_req) begin
                    state_d   = ST_FLUSH;
                    blk_cnt_d = FLUSH_LOAD;
                end
            end
            ST_FLUSH: begin
                if (flush_req) begin
                    blk_cnt_d = FLUSH_LOAD;
                end else if (blk_cnt_q == BLK_W'(1)) begin
                    state_d   = ST_RUN;
                    blk_cnt_d = '0;
                end else begin
                    blk_cnt_d = blk_cnt_q - BLK_W'(1);
                end
            end
            default: begin
                state_d   = ST_RUN;
                blk_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_RUN;
            blk_cnt_q   <= '0;
            rat_bco_q   <= 1'b0;
            rat_snoop_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            blk_cnt_q   <= blk_cnt_d;
            // Requests in either state produce exactly one pulse per request cycle.
            rat_bco_q   <= bco_in;
            rat_snoop_q <= snoop_in;
            err_q       <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Pointer tracker
    // ------------------------------------------------------------------
    decode_rob_ptr #(
        .DEPTH (ROB_DEPTH)
    ) u_ptr (
        .clk      (clk),
        .rst_ni   (resetn),
        .alloc_i  (alloc_en),
        .commit_i (commit_en),
        .clear_i  (flush_req),
        .tail_o   (tail),
        .count_o  (count),
        .full_o   (full),
        .empty_o  (empty)
    );

    // ------------------------------------------------------------------
    // Output mapping. While resetn is low the combinational outputs are
    // forced to their idle values (s_ready high, everything else zero) so
    // the RAT never sees a write during reset regardless of inputs.
    // ------------------------------------------------------------------
    assign alloc_en  = resetn & s_valid & run_ready;
    assign commit_en = resetn & commit_go;

    assign s_ready       = ~resetn | run_ready;
    assign s_rob         = tail;

    assign rat_wec       = alloc_en & s_dst_we & (s_dst != '0);
    assign rat_addrc     = resetn ? s_dst : '0;
    assign rat_dinc_fid  = resetn ? s_fid : '0;
    assign rat_dinc_rob  = tail;

    assign rat_wee       = commit_en & c_dst_we & (c_dst != '0);
    assign rat_addre     = resetn ? c_dst : '0;
    assign rat_dine_fid  = resetn ? c_fid : '0;

    assign rat_bco       = rat_bco_q;
    assign rat_snoop     = rat_snoop_q;
    assign err_underflow = err_q;

`ifdef DECODE_ROB_ALLOC_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (s_valid & ~s_ready & (stall_cnt_q != 16'hFFFF))
            stall_cnt_d = stall_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) stall_cnt_q <= '0;
        else         stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_decode_rob_alloc.sv
// ---------------------------------------------------------------------------
// tb_decode_rob_alloc
// Directed scenarios followed by randomized traffic, every cycle compared
// against a cycle-level occupancy/blackout model of the allocator.
// ---------------------------------------------------------------------------
module tb_decode_rob_alloc;

    localparam int DEPTH = 16;
    localparam int FC    = 2;

    logic       clk;
    logic       resetn;
    logic       s_valid;
    logic       s_ready;
    logic [4:0] s_dst;
    logic       s_dst_we;
    logic [7:0] s_fid;
    logic [3:0] s_rob;
    logic       c_valid;
    logic [4:0] c_dst;
    logic       c_dst_we;
    logic [7:0] c_fid;
    logic       bco_in;
    logic       snoop_in;
    logic       rat_wec;
    logic [4:0] rat_addrc;
    logic [7:0] rat_dinc_fid;
    logic [3:0] rat_dinc_rob;
    logic       rat_wee;
    logic [4:0] rat_addre;
    logic [7:0] rat_dine_fid;
    logic       rat_bco;
    logic       rat_snoop;
    logic [4:0] count;
    logic       err_underflow;
`ifdef DECODE_ROB_ALLOC_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    decode_rob_alloc #(
        .ROB_DEPTH    (DEPTH),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_dst         (s_dst),
        .s_dst_we      (s_dst_we),
        .s_fid         (s_fid),
        .s_rob         (s_rob),
        .c_valid       (c_valid),
        .c_dst         (c_dst),
        .c_dst_we      (c_dst_we),
        .c_fid         (c_fid),
        .bco_in        (bco_in),
        .snoop_in      (snoop_in),
        .rat_wec       (rat_wec),
        .rat_addrc     (rat_addrc),
        .rat_dinc_fid  (rat_dinc_fid),
        .rat_dinc_rob  (rat_dinc_rob),
        .rat_wee       (rat_wee),
        .rat_addre     (rat_addre),
        .rat_dine_fid  (rat_dine_fid),
        .rat_bco       (rat_bco),
        .rat_snoop     (rat_snoop),
        .count         (count),
        .err_underflow (err_underflow)
`ifdef DECODE_ROB_ALLOC_STALL_CNT_EN
        ,
        .stall_cnt     (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: occupancy, next tag, remaining blackout cycles.
    int m_count;
    int m_tail;
    int m_blk;
    bit m_bco;
    bit m_snp;
    bit m_err;
    int m_stall;

    task automatic model_reset();
        m_count = 0; m_tail = 0; m_blk = 0;
        m_bco = 0; m_snp = 0; m_err = 0; m_stall = 0;
    endtask

    // One clock cycle: drive inputs, check combinational and registered
    // outputs at the falling edge, then advance the model at the rising edge.
    task automatic step(input bit sv, input int dst, input bit dwe, input int fid,
                        input bit cv, input int cdst, input bit cdwe, input int cfid,
                        input bit b, input bit sn);
        bit flush, running, e_ready, hs, cm, e_wec, e_wee;
        logic [7:0] fid8, cfid8;
        logic [4:0] dst5, cdst5;
        fid8 = fid[7:0]; cfid8 = cfid[7:0]; dst5 = dst[4:0]; cdst5 = cdst[4:0];
        s_valid = sv; s_dst = dst5; s_dst_we = dwe; s_fid = fid8;
        c_valid = cv; c_dst = cdst5; c_dst_we = cdwe; c_fid = cfid8;
        bco_in = b; snoop_in = sn;

        flush   = b | sn;
        running = (m_blk == 0);
        e_ready = running && (m_count < DEPTH) && !flush;
        hs      = sv && e_ready;
        cm      = running && !flush && cv && (m_count > 0);
        e_wec   = hs && dwe && (dst5 != 0);
        e_wee   = cm && cdwe && (cdst5 != 0);

        @(negedge clk);
        chk("s_ready",       32'(s_ready),       32'(e_ready));
        chk("s_rob",         32'(s_rob),         32'(m_tail));
        chk("rat_wec",       32'(rat_wec),       32'(e_wec));
        chk("rat_addrc",     32'(rat_addrc),     32'(dst5));
        chk("rat_dinc_fid",  32'(rat_dinc_fid),  32'(fid8));
        chk("rat_dinc_rob",  32'(rat_dinc_rob),  32'(m_tail));
        chk("rat_wee",       32'(rat_wee),       32'(e_wee));
        chk("rat_addre",     32'(rat_addre),     32'(cdst5));
        chk("rat_dine_fid",  32'(rat_dine_fid),  32'(cfid8));
        chk("rat_bco",       32'(rat_bco),       32'(m_bco));
        chk("rat_snoop",     32'(rat_snoop),     32'(m_snp));
        chk("count",         32'(count),         32'(m_count));
        chk("err_underflow", 32'(err_underflow), 32'(m_err));
`ifdef DECODE_ROB_ALLOC_STALL_CNT_EN
        chk("stall_cnt",     32'(stall_cnt),     32'(m_stall));
`endif
        if (hs)
            $display("[TB] alloc  rob=%0d dst=%0d we=%0d fid=%02h wec=%0d count=%0d",
                     m_tail, dst5, dwe, fid8, rat_wec, count);
        if (cm)
            $display("[TB] commit dst=%0d we=%0d fid=%02h wee=%0d count=%0d",
                     cdst5, cdwe, cfid8, rat_wee, count);
        if (flush)
            $display("[TB] flush  bco=%0d snoop=%0d count=%0d", b, sn, count);

        @(posedge clk);
        if (sv && !e_ready && m_stall < 65535) m_stall++;
        if (flush) begin
            m_count = 0; m_tail = 0; m_blk = FC;
        end else if (!running) begin
            m_blk--;
        end else begin
            if (cv && m_count == 0) m_err = 1;
            if (hs) begin m_tail = (m_tail + 1) % DEPTH; m_count++; end
            if (cm) m_count--;
        end
        m_bco = b;
        m_snp = sn;
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic alloc(input int dst, input int fid);
        step(1, dst, 1, fid, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        resetn = 1'b0;
        s_valid = 0; s_dst = 0; s_dst_we = 0; s_fid = 0;
        c_valid = 0; c_dst = 0; c_dst_we = 0; c_fid = 0;
        bco_in = 0; snoop_in = 0;
        model_reset();

        #12;
        chk("rst_s_ready", 32'(s_ready),       32'd1);
        chk("rst_count",   32'(count),         32'd0);
        chk("rst_err",     32'(err_underflow), 32'd0);
        chk("rst_rat_bco", 32'(rat_bco),       32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;

        // Three allocations, one with the zero register as destination.
        alloc(5, 8'h10);
        alloc(0, 8'h11);
        alloc(7, 8'h12);
        chk("count_after_3", 32'(count), 32'd3);

        // Fill to full, observe backpressure and the tag wrap.
        for (int i = 0; i < 13; i++) alloc(i + 1, 8'h20 + i);
        chk("count_full", 32'(count), 32'd16);
        alloc(9, 8'h40);                              // refused: full
        step(1, 9, 1, 8'h40, 1, 5, 1, 8'h10, 0, 0);   // commit at full, no refill
        alloc(9, 8'h41);                              // accepted, tag 0

        // Clear, refill to 4, then simultaneous allocate and commit.
        step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(); idle();
        for (int i = 0; i < 4; i++) alloc(i + 2, 8'h50 + i);
        step(1, 3, 1, 8'h60, 1, 2, 1, 8'h50, 0, 0);
        chk("count_alloc_commit", 32'(count), 32'd4);
        alloc(4, 8'h61);

        // Branch correction at count 5 with a concurrent commit.
        step(0, 0, 0, 0, 1, 3, 1, 8'h51, 1, 0);
        chk("count_post_bco", 32'(count), 32'd0);
        alloc(6, 8'h70);
        alloc(6, 8'h71);
        alloc(6, 8'h72);                              // first accepted, tag 0

        // Snoop flush, then underflow commit and its stickiness.
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(); idle();
        step(0, 0, 0, 0, 1, 4, 1, 8'h80, 0, 0);
        idle();
        alloc(8, 8'h81);
        chk("err_sticky", 32'(err_underflow), 32'd1);

        // Asynchronous reset while in blackout with a pulse pending.
        step(1, 9, 1, 8'h90, 1, 8, 1, 8'h81, 1, 0);
        s_valid = 1; s_dst = 5'd9; s_dst_we = 1; c_valid = 1; c_dst = 5'd8; c_dst_we = 1;
        #2;
        resetn = 1'b0;
        #1;
        chk("arst_s_ready", 32'(s_ready),       32'd1);
        chk("arst_count",   32'(count),         32'd0);
        chk("arst_rat_bco", 32'(rat_bco),       32'd0);
        chk("arst_snoop",   32'(rat_snoop),     32'd0);
        chk("arst_err",     32'(err_underflow), 32'd0);
        chk("arst_wec",     32'(rat_wec),       32'd0);
        chk("arst_wee",     32'(rat_wee),       32'd0);
        chk("arst_s_rob",   32'(s_rob),         32'd0);
        @(posedge clk); #1;
        resetn = 1'b1;
        model_reset();
        alloc(3, 8'hA0);

        // Randomized traffic with varying commit pressure.
        for (int i = 0; i < 1500; i++) begin
            int cprob;
            bit fl;
            cprob = 20 + 30 * ((i / 150) % 3);
            fl = ($urandom_range(99) < 3);
            step($urandom_range(99) < 70, $urandom_range(31), $urandom_range(1), $urandom_range(255),
                 $urandom_range(99) < cprob, $urandom_range(31), $urandom_range(1), $urandom_range(255),
                 fl && $urandom_range(1) == 1, fl && $urandom_range(2) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_rob_alloc.md
Name: decode_rob_alloc

Overview:
- In-order ROB-index allocator and sequencer for the decode-stage register alias table (RAT), sitting between decode and the RAT write ports.
- Hands out 4-bit ROB tags from a circular pointer pair and drives the RAT allocate port (wec/addrc/dinc_fid/dinc_rob).
- Forwards in-order commits to the RAT commit port (wee/addre/dine_fid).
- Sequences recovery on branch-correction (BCO) or snoop hit: flush pulse to the RAT, pointer reset, then an allocation blackout.

Parameters:
- ROB_DEPTH, 16, number of ROB entries; must be a power of two, at most 16 (tag width is 4 bits).
- FLUSH_CYCLES, 2, allocation-blocked cycles after a flush pulse; range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- s_valid  in  1  decode presents an instruction
- s_ready  out  1  allocator can accept
- s_dst  in  5  destination architectural register
- s_dst_we  in  1  instruction writes s_dst
- s_fid  in  8  fetch id of the instruction
- s_rob  out  4  ROB tag assigned; valid while s_valid & s_ready
- c_valid  in  1  in-order commit of the oldest entry
- c_dst  in  5  committed destination register
- c_dst_we  in  1  committed instruction wrote c_dst
- c_fid  in  8  fetch id of the committed instruction
- bco_in  in  1  branch-correction request
- snoop_in  in  1  snoop-hit request
- rat_wec  out  1  RAT allocate write enable
- rat_addrc  out  5  RAT allocate address
- rat_dinc_fid  out  8  RAT allocate fid
- rat_dinc_rob  out  4  RAT allocate ROB tag
- rat_wee  out  1  RAT commit enable
- rat_addre  out  5  RAT commit address
- rat_dine_fid  out  8  RAT commit fid
- rat_bco  out  1  RAT flush pulse
- rat_snoop  out  1  RAT snoop flush pulse
- count  out  5  occupied ROB entries, 0..ROB_DEPTH
- err_underflow  out  1  sticky: commit seen while empty

Behaviour:
- Reset (async, resetn=0):
  - head=0, tail=0, count=0, state=RUN, blk_cnt=0.
  - rat_bco=0, rat_snoop=0, err_underflow=0.
  - All combinational outputs evaluate to 0 except s_ready=1.
- State RUN:
  - s_ready = (count != ROB_DEPTH) & ~bco_in & ~snoop_in.
  - Allocation handshake = s_valid & s_ready.
  - s_rob = tail (combinational).
- Allocation on handshake:
  - tail <= tail+1 mod ROB_DEPTH.
  - rat_wec = handshake & s_dst_we & (s_dst != 0), combinational, same cycle.
  - rat_addrc = s_dst; rat_dinc_fid = s_fid; rat_dinc_rob = tail.
- Commit:
  - On c_valid & (count != 0): head <= head+1.
  - rat_wee = c_valid & c_dst_we & (c_dst != 0) & (count != 0), combinational.
  - rat_addre = c_dst; rat_dine_fid = c_fid.
  - On c_valid while count==0: no pointer change, rat_wee=0, err_underflow <= 1 (cleared only by reset).
- Count update:
  - +1 on allocate, -1 on commit, unchanged when both occur in the same cycle.
  - At count==ROB_DEPTH with a commit this cycle, s_ready stays 0 (no same-cycle refill).
- Flush (bco_in | snoop_in in RUN):
  - Next edge: rat_bco <= bco_in, rat_snoop <= snoop_in (one-cycle registered pulses).
  - Same edge: head=tail=count=0, state <= FLUSH, blk_cnt <= FLUSH_CYCLES.
  - The commit in the same cycle is discarded (rat_wee forced 0).
- State FLUSH:
  - s_ready=0; rat_wec=0; rat_wee=0; c_valid ignored.
  - blk_cnt decrements each cycle; at blk_cnt==1 -> RUN.
  - bco_in/snoop_in in FLUSH re-pulse the RAT and reload blk_cnt=FLUSH_CYCLES.
- Priority: reset > flush request > commit/allocate.
- Reset mid-flush: immediate return to RUN with empty state; no pending pulse survives.

Optional Feature:
- Macro DECODE_ROB_ALLOC_STALL_CNT_EN.
- Defined: adds port stall_cnt (out, 16 bits).
  - Saturating counter (holds at 16'hFFFF) incremented each cycle s_valid=1 & s_ready=0.
  - Reset to 0 by resetn only; flushes do not clear it.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package decode_pkg holds the shared definitions:
  - ROB_TAG_W=4, ARCH_REG_W=5, FID_W=8.
  - State enum {RUN, FLUSH}.
  - DEFAULT_FLUSH_CYCLES=2.
- Sub-module decode_rob_ptr: a circular head/tail/count tracker with alloc/commit/clear inputs, full/empty outputs and wrap logic. The top level keeps the FSM and RAT port mapping.

Test Plan:
- Allocate 3 instructions (dst 5, 0, 7; fid 0x10, 0x11, 0x12) -> s_rob 0, 1, 2; rat_wec only for dst 5 (rob 0) and dst 7 (rob 2); count=3.
- Allocate 16 with no commits -> s_ready=0 at count=16; tail wraps to 0. Commit once -> s_ready=1 the following cycle; next s_rob=0.
- Simultaneous allocate + commit at count=4 -> count stays 4; rat_wec and rat_wee both asserted that cycle.
- bco_in pulse at count=5 with concurrent c_valid -> rat_bco=1 for exactly one cycle, rat_wee=0, count=0, s_ready=0 for 2 cycles, then the first allocation returns s_rob=0.
- c_valid with count=0 -> rat_wee=0, count stays 0, err_underflow=1 and held until resetn.
- resetn asserted low asynchronously in FLUSH -> all outputs at reset values before the next edge; s_ready=1 after release.
